cpu_design_project: RTL and testbench

//  Phase-1 single-bus datapath: 32-bit bus, PC, IR, MAR, MDR, Y, Z(64b: ZHigh/ZLow), GPRs R1-R3, ALU.

---
 rtl/cpu_design_project.sv | 122 ++++++++++++
 tb/tb_cpu_design_project.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_design_project.sv
// cpu_design_project - single-bus datapath: PC, IR, MAR, MDR, Y, 64-bit Z, R1-R3 and ALU
// All loads are driven by external strobes; there is no internal control unit.
module cpu_design_project #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             PCout,
   input  logic             Zlowout,
   input  logic             MDRout,
   input  logic             R2out,
   input  logic             R3out,
   input  logic             MARin,
   input  logic             ZLowIn,
   input  logic             PCin,
   input  logic             MDRin,
   input  logic             IRin,
   input  logic             Yin,
   input  logic             IncPC,
   input  logic             Read,
   input  logic [4:0]       OR,
   input  logic             R1in,
   input  logic             R2in,
   input  logic             R3in,
   input  logic [WIDTH-1:0] Mdatain,
   output logic [WIDTH-1:0] MDR_output
);

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_SUB = 5'b00100;
   localparam logic [4:0] OP_AND = 5'b00101;
   localparam logic [4:0] OP_OR  = 5'b00110;
   localparam logic [4:0] OP_SHR = 5'b00111;
   localparam logic [4:0] OP_SHL = 5'b01000;
   localparam logic [4:0] OP_ROR = 5'b01001;
   localparam logic [4:0] OP_ROL = 5'b01010;
   localparam logic [4:0] OP_NEG = 5'b01111;
   localparam logic [4:0] OP_NOT = 5'b10000;

   logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
   logic [WIDTH-1:0]   r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
   logic [2*WIDTH-1:0] z_q, z_d;
   logic [WIDTH-1:0]   bus;
   logic [2*WIDTH-1:0] alu_result;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] rot_right, rot_left;
   logic [4:0]         shamt;

   always_comb begin
      bus = '0;
      if (MDRout)       bus = mdr_q;
      else if (Zlowout) bus = z_q[WIDTH-1:0];
      else if (PCout)   bus = pc_q;
      else if (R2out)   bus = r2_q;
      else if (R3out)   bus = r3_q;
   end

   // Rotates shift a doubled copy of Y so the wrapped bits fall into the kept half.
   always_comb begin
      shamt      = bus[4:0];
      sum        = {1'b0, y_q} + {1'b0, bus};
      rot_right  = {y_q, y_q} >> shamt;
      rot_left   = {y_q, y_q} << shamt;
      alu_result = '0;
      if (IncPC) begin
         alu_result = {{WIDTH{1'b0}}, bus + {{(WIDTH-1){1'b0}}, 1'b1}};
      end else begin
         case (OR)
            OP_ADD:  alu_result = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB:  alu_result = {{WIDTH{1'b0}}, y_q - bus};
            OP_AND:  alu_result = {{WIDTH{1'b0}}, y_q & bus};
            OP_OR:   alu_result = {{WIDTH{1'b0}}, y_q | bus};
            OP_SHR:  alu_result = {{WIDTH{1'b0}}, y_q >> shamt};
            OP_SHL:  alu_result = {{WIDTH{1'b0}}, y_q << shamt};
            OP_ROR:  alu_result = {{WIDTH{1'b0}}, rot_right[WIDTH-1:0]};
            OP_ROL:  alu_result = {{WIDTH{1'b0}}, rot_left[2*WIDTH-1:WIDTH]};
            OP_NEG:  alu_result = {{WIDTH{1'b0}}, -bus};
            OP_NOT:  alu_result = {{WIDTH{1'b0}}, ~bus};
            default: alu_result = '0;
         endcase
      end
   end

   always_comb begin
      pc_d  = PCin  ? bus : pc_q;
      ir_d  = IRin  ? bus : ir_q;
      mar_d = MARin ? bus : mar_q;
      mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
      y_d   = Yin   ? bus : y_q;
      z_d   = ZLowIn ? alu_result : z_q;
      r1_d  = R1in  ? bus : r1_q;
      r2_d  = R2in  ? bus : r2_q;
      r3_d  = R3in  ? bus : r3_q;
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         y_q   <= '0;
         z_q   <= '0;
         r1_q  <= '0;
         r2_q  <= '0;
         r3_q  <= '0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
         y_q   <= y_d;
         z_q   <= z_d;
         r1_q  <= r1_d;
         r2_q  <= r2_d;
         r3_q  <= r3_d;
      end
   end

   assign MDR_output = mdr_q;

endmodule

// File: tb/tb_cpu_design_project.sv
// tb/tb_cpu_design_project.sv - table-driven and scoreboard bench for cpu_design_project
module tb_cpu_design_project;

   logic        Clock, Clear;
   logic        PCout, Zlowout, MDRout, R2out, R3out;
   logic        MARin, ZLowIn, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic [4:0]  OR;
   logic        R1in, R2in, R3in;
   logic [31:0] Mdatain;
   logic [31:0] MDR_output;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic        inc;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;
   vec_t vecs[15];

   cpu_design_project #(.WIDTH(32)) dut (
      .Clock(Clock), .Clear(Clear),
      .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
      .MARin(MARin), .ZLowIn(ZLowIn), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .IncPC(IncPC), .Read(Read), .OR(OR), .R1in(R1in), .R2in(R2in), .R3in(R3in),
      .Mdatain(Mdatain), .MDR_output(MDR_output)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [31:0] exp);
      sb_t e;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop_check(input logic [31:0] act);
      sb_t e;
      if (sb_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard_empty: got %h, required a queued entry", act);
      end else begin
         e = sb_q.pop_front();
         check(e.name, {32'h0, act}, {32'h0, e.exp});
      end
   endtask

   task automatic clr_strobes();
      PCout = 0; Zlowout = 0; MDRout = 0; R2out = 0; R3out = 0;
      MARin = 0; ZLowIn = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
      IncPC = 0; Read = 0; R1in = 0; R2in = 0; R3in = 0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
      clr_strobes();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Mdatain = v; Read = 1; MDRin = 1;
      tick();
   endtask

   // Route ZLow through MDR so the result is visible on the output port.
   task automatic zlow_to_mdr();
      Zlowout = 1; MDRin = 1; Read = 0;
      tick();
   endtask

   initial begin
      vecs[0]  = '{"add_carry", 5'b00011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000001_00000000};
      vecs[1]  = '{"sub_pos",   5'b00100, 1'b0, 32'h00000014, 32'h00000012, 64'h00000000_00000002};
      vecs[2]  = '{"sub_neg",   5'b00100, 1'b0, 32'h00000012, 32'h00000014, 64'h00000000_FFFFFFFE};
      vecs[3]  = '{"and",       5'b00101, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000};
      vecs[4]  = '{"or",        5'b00110, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 64'h00000000_FFFFF0F0};
      vecs[5]  = '{"shr",       5'b00111, 1'b0, 32'h80000000, 32'h00000024, 64'h00000000_08000000};
      vecs[6]  = '{"shl",       5'b01000, 1'b0, 32'h00000001, 32'h0000001F, 64'h00000000_80000000};
      vecs[7]  = '{"ror",       5'b01001, 1'b0, 32'h00000001, 32'h00000001, 64'h00000000_80000000};
      vecs[8]  = '{"rol",       5'b01010, 1'b0, 32'h80000001, 32'h00000001, 64'h00000000_00000003};
      vecs[9]  = '{"rol_zero",  5'b01010, 1'b0, 32'h12345678, 32'h00000020, 64'h00000000_12345678};
      vecs[10] = '{"neg",       5'b01111, 1'b0, 32'h00000007, 32'h00000001, 64'h00000000_FFFFFFFF};
      vecs[11] = '{"not",       5'b10000, 1'b0, 32'h00000007, 32'h0000FFFF, 64'h00000000_FFFF0000};
      vecs[12] = '{"undef_31",  5'b11111, 1'b0, 32'h00000005, 32'h00000006, 64'h0};
      vecs[13] = '{"undef_0",   5'b00000, 1'b0, 32'h00000005, 32'h00000006, 64'h0};
      vecs[14] = '{"incpc_pri", 5'b00011, 1'b1, 32'h00000005, 32'hFFFFFFFF, 64'h0};

      clr_strobes();
      OR = 5'b0; Mdatain = 32'h0;
      Clear = 0;
      #2;
      check("reset_mdr_out", {32'h0, MDR_output}, 64'h0);
      check("reset_pc", {32'h0, dut.pc_q}, 64'h0);
      check("reset_z", dut.z_q, 64'h0);
      check("idle_bus", {32'h0, dut.bus}, 64'h0);
      #10;
      Clear = 1;
      @(posedge Clock); #1;

      load_mdr(32'h12);
      sb_push("mdr_load", 32'h12);
      sb_pop_check(MDR_output);
      MDRout = 1; R2in = 1; tick();
      load_mdr(32'h14);
      MDRout = 1; R3in = 1; tick();
      load_mdr(32'h18);
      MDRout = 1; R1in = 1; tick();
      R2out = 1; MDRin = 1; Read = 0; tick();
      sb_push("r2_value", 32'h12);
      sb_pop_check(MDR_output);
      R3out = 1; MDRin = 1; Read = 0; tick();
      sb_push("r3_value", 32'h14);
      sb_pop_check(MDR_output);
      check("r1_value", {32'h0, dut.r1_q}, 64'h18);

      PCout = 1; MARin = 1; IncPC = 1; ZLowIn = 1; tick();
      check("fetch_mar", {32'h0, dut.mar_q}, 64'h0);
      check("fetch_zlow", dut.z_q, 64'h1);
      Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h1848C000; tick();
      check("fetch_pc", {32'h0, dut.pc_q}, 64'h1);
      sb_push("fetch_mdr", 32'h1848C000);
      sb_pop_check(MDR_output);
      MDRout = 1; IRin = 1; tick();
      check("fetch_ir", {32'h0, dut.ir_q}, 64'h1848C000);

      R2out = 1; Yin = 1; tick();
      check("or_y", {32'h0, dut.y_q}, 64'h12);
      R3out = 1; OR = 5'b00110; ZLowIn = 1; tick();
      Zlowout = 1; R1in = 1; tick();
      check("or_r1", {32'h0, dut.r1_q}, 64'h16);

      for (int i = 0; i < 15; i++) begin
         load_mdr(vecs[i].a);
         MDRout = 1; Yin = 1; tick();
         load_mdr(vecs[i].b);
         MDRout = 1; OR = vecs[i].op; IncPC = vecs[i].inc; ZLowIn = 1;
         sb_push(vecs[i].name, vecs[i].exp[31:0]);
         tick();
         check({vecs[i].name, "_zhigh"}, {32'h0, dut.z_q[63:32]}, {32'h0, vecs[i].exp[63:32]});
         zlow_to_mdr();
         sb_pop_check(MDR_output);
      end

      load_mdr(32'hAAAA5555);
      MDRout = 1; R2out = 1; Yin = 1;
      #1;
      check("bus_priority", {32'h0, dut.bus}, 64'hAAAA5555);
      tick();
      check("priority_y", {32'h0, dut.y_q}, 64'hAAAA5555);

      load_mdr(32'hFFFFFFFF);
      MDRout = 1; PCin = 1; tick();
      PCout = 1; IncPC = 1; OR = 5'b00011; ZLowIn = 1; tick();
      check("pc_wrap_zhigh", {32'h0, dut.z_q[63:32]}, 64'h0);
      zlow_to_mdr();
      sb_push("pc_wrap_zlow", 32'h0);
      sb_pop_check(MDR_output);

      OR = 5'b00011;
      load_mdr(32'h5);
      check("hold_r2", {32'h0, dut.r2_q}, 64'h12);
      #2;
      Clear = 0;
      #1;
      check("mid_clear_mdr", {32'h0, MDR_output}, 64'h0);
      check("mid_clear_r2", {32'h0, dut.r2_q}, 64'h0);
      check("mid_clear_pc", {32'h0, dut.pc_q}, 64'h0);
      @(negedge Clock);
      Clear = 1;
      @(posedge Clock); #1;

      if (sb_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
